// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one shared full-adder slice stepped LSB-first,
// running carry held in a flop, registered Sum/Carry with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_shift;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             p, g1, s, g2, c_next, last;

  // Shared 1-bit slice: two half adders with the carries ORed
  always_comb begin
    p         = a_sr[0] ^ b_sr[0];
    g1        = a_sr[0] & b_sr[0];
    s         = p ^ c;
    g2        = p & c;
    c_next    = g1 | g2;
    last      = (cnt == CW'(WIDTH - 1));
    res_shift = WIDTH'({s, res_sr} >> 1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus busy/done registered as decodes of the new state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Operand/result shift registers, carry flop, bit counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      Sum    <= '0;
      Carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= A;
            b_sr <= B;
            c    <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          c      <= c_next;
          res_sr <= res_shift;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            Sum   <= res_shift;
            Carry <= c_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances,
// expected {Carry,Sum} queued at stimulus time and popped when done appears.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, carry8, busy1, done1, carry1;
  logic [7:0] sum8;
  logic [0:0] sum1;

  int total = 0;
  int bad   = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .Sum(sum1), .Carry(carry1)
  );

  // Drive one WIDTH=8 operation and observe it up to and including the done cycle
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b,
                         output int busy_cnt, output logic busy_at_done,
                         output bit held, output bit timeout);
    logic [7:0] prev_s;
    logic       prev_c;
    int         cyc;
    prev_s = sum8;
    prev_c = carry8;
    busy_cnt = 0;
    held = 1'b1;
    a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back(9'(a) + 9'(b));
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) busy_cnt++;
      if (sum8 !== prev_s || carry8 !== prev_c) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    timeout = (done8 !== 1'b1);
    busy_at_done = busy8;
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
    total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum8); end
    total++; if (carry8 !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry8); end
    start8 = 1'b0; start1 = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_nostart got=%b exp=0", busy8); end
  endtask

  task automatic test_add(input logic [7:0] a, input logic [7:0] b, input string name);
    int         bc;
    logic       bd;
    bit         held, to;
    logic [8:0] exp;
    do_add8(a, b, bc, bd, held, to);
    total++;
    if (to) begin bad++; $display("FAIL %s_timeout no done seen", name); end
    else begin
      exp = q8.pop_front();
      total++; if (bc != 8) begin bad++; $display("FAIL %s_busycycles got=%0d exp=8", name, bc); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done got=%b exp=0", name, bd); end
      total++; if (held !== 1'b1) begin bad++; $display("FAIL %s_hold result changed during busy", name); end
      total++; if (sum8 !== exp[7:0]) begin bad++; $display("FAIL %s_sum got=%h exp=%h", name, sum8, exp[7:0]); end
      total++; if (carry8 !== exp[8]) begin bad++; $display("FAIL %s_carry got=%b exp=%b", name, carry8, exp[8]); end
    end
    @(negedge clk);
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL %s_done_width got=%b exp=0", name, done8); end
  endtask

  task automatic test_ignored_start;
    int         dones;
    int         cyc;
    logic [8:0] exp;
    dones = 0;
    a8 = 8'h55; b8 = 8'hAA; start8 = 1'b1;
    q8.push_back(9'(8'h55) + 9'(8'hAA));
    @(negedge clk);
    start8 = 1'b0;
    for (cyc = 0; cyc < 30; cyc++) begin
      start8 = 1'b0;
      if (done8 === 1'b1) begin
        dones++;
        if (dones == 1) begin
          exp = q8.pop_front();
          total++; if (sum8 !== exp[7:0]) begin bad++; $display("FAIL ign_sum got=%h exp=%h", sum8, exp[7:0]); end
          total++; if (carry8 !== exp[8]) begin bad++; $display("FAIL ign_carry got=%b exp=%b", carry8, exp[8]); end
          a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        end
      end else if (cyc == 3) begin
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
      end
      @(negedge clk);
    end
    total++; if (dones != 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL ign_idle got=%b exp=0", busy8); end
  endtask

  task automatic test_reset_mid;
    int bc;
    int dones;
    bc = 0; dones = 0;
    a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 20 && bc < 4; i++) begin
      if (busy8 === 1'b1) bc++;
      if (bc < 4) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done8); end
    total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL mid_sum got=%h exp=00", sum8); end
    total++; if (carry8 !== 1'b0) begin bad++; $display("FAIL mid_carry got=%b exp=0", carry8); end
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1) dones++;
      @(negedge clk);
    end
    total++; if (dones != 0) begin bad++; $display("FAIL mid_stray_done got=%0d exp=0", dones); end
    test_add(8'h03, 8'h04, "mid_fresh");
  endtask

  task automatic test_back_to_back;
    int         at[3];
    int         n;
    logic [8:0] exp;
    n = 0;
    a8 = 8'h05; b8 = 8'h09; start8 = 1'b1;
    for (int i = 0; i < 3; i++) q8.push_back(9'(8'h05) + 9'(8'h09));
    for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        at[n] = cyc;
        n++;
        exp = q8.pop_front();
        total++; if ({carry8, sum8} !== exp) begin bad++; $display("FAIL b2b_result got=%h exp=%h", {carry8, sum8}, exp); end
        if (n == 3) start8 = 1'b0;
      end
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", n); end
    else begin
      total++; if (at[1] - at[0] != 10) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=10", at[1] - at[0]); end
      total++; if (at[2] - at[1] != 10) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=10", at[2] - at[1]); end
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL b2b_stop got=%b exp=0", busy8); end
  endtask

  task automatic test_width1;
    logic [1:0] exp;
    a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
    q1.push_back(2'(a1) + 2'(b1));
    @(negedge clk);
    start1 = 1'b0;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL w1_busy got=%b exp=1", busy1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL w1_early_done got=%b exp=0", done1); end
    @(negedge clk);
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL w1_busy_end got=%b exp=0", busy1); end
    total++;
    if (done1 !== 1'b1) begin bad++; $display("FAIL w1_done got=%b exp=1", done1); end
    else begin
      exp = q1.pop_front();
      total++; if (sum1 !== exp[0]) begin bad++; $display("FAIL w1_sum got=%b exp=%b", sum1, exp[0]); end
      total++; if (carry1 !== exp[1]) begin bad++; $display("FAIL w1_carry got=%b exp=%b", carry1, exp[1]); end
    end
    @(negedge clk);
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL w1_done_width got=%b exp=0", done1); end
  endtask

  initial begin
    test_reset();
    test_add(8'h0F, 8'h01, "basic");
    test_add(8'hFF, 8'h01, "ff_01");
    test_add(8'hFF, 8'hFF, "ff_ff");
    test_add(8'h00, 8'h00, "zero");
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
